// File: rtl/poly_mult_pkg.sv
// Shared types and defaults for the polynomial multiplier back end.
// The negacyclic fold stage pulls its state encoding and default sizes from here.
package poly_mult_pkg;

    localparam int POLY_N_DEF      = 8;
    localparam int INPUT_WIDTH_DEF = 8;
    localparam int IDX_W           = $clog2(POLY_N_DEF);

    typedef logic [INPUT_WIDTH_DEF-1:0] coeff_t;

    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        STREAM = 1'b1
    } fold_state_e;

endpackage

// File: rtl/coeff_fold.sv
// One negacyclic fold column: lo - hi modulo 2^W, with hi forced to zero
// for the top coefficient, which has no partner above x^(2N-2).
module coeff_fold #(
    parameter int W = 8
) (
    input  logic [W-1:0] lo,
    input  logic [W-1:0] hi,
    input  logic         is_top,
    output logic [W-1:0] diff
);

    assign diff = lo - (is_top ? {W{1'b0}} : hi);

endmodule

// File: rtl/negacyclic_fold_stage.sv
// Captures one linear-convolution product and streams its fold into
// Z_(2^W)[x]/(x^N+1), one coefficient per beat, under valid/ready.
module negacyclic_fold_stage
    import poly_mult_pkg::*;
#(
    parameter int POLY_N      = POLY_N_DEF,
    parameter int INPUT_WIDTH = INPUT_WIDTH_DEF
) (
    input  logic                                  clk,
    input  logic                                  reset,
    input  logic                                  in_valid,
    output logic                                  in_ready,
    input  logic [2*POLY_N-2:0][INPUT_WIDTH-1:0]  in_coeffs,
    output logic                                  out_valid,
    input  logic                                  out_ready,
    output logic [INPUT_WIDTH-1:0]                out_data,
    output logic [$clog2(POLY_N)-1:0]             out_index,
    output logic                                  out_last
);

    localparam int IDX_BITS = $clog2(POLY_N);
    localparam logic [IDX_BITS-1:0] LAST_IDX = IDX_BITS'(POLY_N - 1);

    fold_state_e                           state_q;
    logic [2*POLY_N-2:0][INPUT_WIDTH-1:0]  buf_q;
    logic [INPUT_WIDTH-1:0]                out_data_q;
    logic [IDX_BITS-1:0]                   idx_q;
    logic                                  out_valid_q;

    logic [POLY_N-1:0][INPUT_WIDTH-1:0]    lo_vec;
    logic [POLY_N-1:0][INPUT_WIDTH-1:0]    hi_vec;
    logic [IDX_BITS-1:0]                   idx_next;
    logic [INPUT_WIDTH-1:0]                fold_lo;
    logic [INPUT_WIDTH-1:0]                fold_hi;
    logic                                  fold_top;
    logic [INPUT_WIDTH-1:0]                fold_d;
    logic                                  last_beat;
    logic                                  capture;

    // Column view of the buffer; the upper half pairs with the lower half,
    // and the top column has no partner.
    for (genvar gi = 0; gi < POLY_N; gi++) begin : g_cols
        assign lo_vec[gi] = buf_q[gi];
        if (gi < POLY_N - 1) begin : g_pair
            assign hi_vec[gi] = buf_q[gi + POLY_N];
        end else begin : g_top
            assign hi_vec[gi] = '0;
        end
    end

    assign last_beat = out_valid_q & (idx_q == LAST_IDX);
    assign in_ready  = ~reset & ((state_q == IDLE) | (out_ready & last_beat));
    assign capture   = in_valid & in_ready;
    assign idx_next  = idx_q + 1'b1;

    // A capturing edge folds r[0] straight from the input, since the buffer
    // only holds the new product after that same edge.
    always_comb begin
        fold_lo  = lo_vec[idx_next];
        fold_hi  = hi_vec[idx_next];
        fold_top = (idx_next == LAST_IDX);
        if (capture) begin
            fold_lo  = in_coeffs[0];
            fold_hi  = in_coeffs[POLY_N];
            fold_top = 1'b0;
        end
    end

    coeff_fold #(
        .W (INPUT_WIDTH)
    ) u_fold (
        .lo     (fold_lo),
        .hi     (fold_hi),
        .is_top (fold_top),
        .diff   (fold_d)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            buf_q       <= '0;
            out_data_q  <= '0;
            idx_q       <= '0;
            out_valid_q <= 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (capture) begin
                        buf_q       <= in_coeffs;
                        out_data_q  <= fold_d;
                        idx_q       <= '0;
                        out_valid_q <= 1'b1;
                        state_q     <= STREAM;
                    end
                end
                STREAM: begin
                    if (out_ready) begin
                        if (capture) begin
                            buf_q       <= in_coeffs;
                            out_data_q  <= fold_d;
                            idx_q       <= '0;
                            out_valid_q <= 1'b1;
                        end else if (last_beat) begin
                            idx_q       <= '0;
                            out_valid_q <= 1'b0;
                            state_q     <= IDLE;
                        end else begin
                            out_data_q  <= fold_d;
                            idx_q       <= idx_next;
                        end
                    end
                end
                default: begin
                    out_valid_q <= 1'b0;
                    state_q     <= IDLE;
                end
            endcase
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_index = idx_q;
    assign out_last  = last_beat;

endmodule
